// File: rtl/mem_arbiter16.sv
// mem_arbiter16 -- shares one single-port synchronous RAM between the
// instruction-fetch port and the data load/store port of cpu16.
//
// At most one RAM access is issued per cycle. Stores beat loads, loads beat
// fetches, but once fetch has been denied STARVE_MAX consecutive cycles it is
// forced to win one cycle. The granted port sees its rdy strobe one cycle
// after the access is issued, together with the RAM read data.
//
// Ports:
//   clk, reset                    system clock, synchronous active-high reset
//   ins_rd_addr/req               fetch request (level) and address
//   ins_rd_data/rdy               fetch completion strobe and read data
//   dat_rw_addr, dat_wr_data      load/store address and store data
//   dat_rd_req, dat_wr_req        load / store requests (level)
//   dat_rd_data/rdy, dat_wr_rdy   load / store completion strobes, load data
//   mem_addr, mem_wr_data         RAM address and write data
//   mem_wr_en, mem_rd_en          RAM strobes (never both high)
//   mem_rd_data                   RAM read data, valid cycle after mem_rd_en

module mem_arbiter16 #(
    parameter int AW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ins_rd_addr,
    input  logic          ins_rd_req,
    output logic [15:0]   ins_rd_data,
    output logic          ins_rd_rdy,
    input  logic [AW-1:0] dat_rw_addr,
    input  logic [15:0]   dat_wr_data,
    input  logic          dat_rd_req,
    input  logic          dat_wr_req,
    output logic [15:0]   dat_rd_data,
    output logic          dat_rd_rdy,
    output logic          dat_wr_rdy,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wr_data,
    output logic          mem_wr_en,
    output logic          mem_rd_en,
    input  logic [15:0]   mem_rd_data
);

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_INS  = 2'd1;
    localparam logic [1:0] G_DRD  = 2'd2;
    localparam logic [1:0] G_DWR  = 2'd3;

    // Keep the counter at least one bit wide so STARVE_MAX=0 still elaborates.
    localparam int SCW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

    logic [1:0]     grant;
    logic [1:0]     resp_q, resp_d;
    logic [SCW-1:0] starve_q, starve_d;
    logic           fetch_forced;

    assign fetch_forced = (STARVE_MAX > 0) && (starve_q == STARVE_LIM) && ins_rd_req;

    always_comb begin
        grant = G_NONE;
        if (reset)            grant = G_NONE;
        else if (fetch_forced) grant = G_INS;
        else if (dat_wr_req)  grant = G_DWR;
        else if (dat_rd_req)  grant = G_DRD;
        else if (ins_rd_req)  grant = G_INS;
    end

    // RAM issue. Address/data are don't-care when no strobe is raised, so the
    // data-port values are the idle default.
    always_comb begin
        mem_addr    = dat_rw_addr;
        mem_wr_data = dat_wr_data;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        case (grant)
            G_INS: begin
                mem_addr  = ins_rd_addr;
                mem_rd_en = 1'b1;
            end
            G_DRD:   mem_rd_en = 1'b1;
            G_DWR:   mem_wr_en = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        resp_d   = grant;
        starve_d = starve_q;
        if (!ins_rd_req || grant == G_INS)
            starve_d = '0;
        else if (starve_q < STARVE_LIM)
            starve_d = starve_q + SCW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_q   <= G_NONE;
            starve_q <= '0;
        end else begin
            resp_q   <= resp_d;
            starve_q <= starve_d;
        end
    end

    // Strobes are masked while reset is held so a response already latched
    // before reset rose never reaches the requester.
    assign ins_rd_rdy  = !reset && (resp_q == G_INS);
    assign dat_rd_rdy  = !reset && (resp_q == G_DRD);
    assign dat_wr_rdy  = !reset && (resp_q == G_DWR);
    assign ins_rd_data = mem_rd_data;
    assign dat_rd_data = mem_rd_data;

endmodule

// File: tb/tb_mem_arbiter16.sv
module tb_mem_arbiter16;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_INS  = 2'd1;
    localparam logic [1:0] K_DRD  = 2'd2;
    localparam logic [1:0] K_DWR  = 2'd3;

    typedef struct {
        logic        rst;
        logic        ins_req;
        logic [15:0] ins_addr;
        logic        drd;
        logic        dwr;
        logic [15:0] daddr;
        logic [15:0] wdata;
        logic [1:0]  kind;   // access expected to be issued this cycle
        logic [15:0] rdata;  // read data expected with next cycle's rdy
    } vec_t;

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] rdata;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ins_rd_addr, dat_rw_addr, dat_wr_data;
    logic        ins_rd_req, dat_rd_req, dat_wr_req;
    logic [15:0] ins_rd_data, dat_rd_data, mem_addr, mem_wr_data, mem_rd_data;
    logic        ins_rd_rdy, dat_rd_rdy, dat_wr_rdy, mem_wr_en, mem_rd_en;

    // second instance with starvation forcing disabled
    logic [15:0] z_ins_addr, z_daddr, z_wdata, z_mem_rd_data;
    logic        z_ins_req, z_drd, z_dwr;
    logic [15:0] z_ins_data, z_drd_data, z_mem_addr, z_mem_wr_data;
    logic        z_ins_rdy, z_drd_rdy, z_dwr_rdy, z_wr_en, z_rd_en;

    int errs   = 0;
    int checks = 0;

    logic [15:0] ram [0:65535];
    vec_t  vecs[$];
    resp_t sb[$];

    always #5 clk = ~clk;

    mem_arbiter16 #(.AW(16), .STARVE_MAX(4)) u_dut (
        .clk(clk), .reset(rst),
        .ins_rd_addr(ins_rd_addr), .ins_rd_req(ins_rd_req),
        .ins_rd_data(ins_rd_data), .ins_rd_rdy(ins_rd_rdy),
        .dat_rw_addr(dat_rw_addr), .dat_wr_data(dat_wr_data),
        .dat_rd_req(dat_rd_req), .dat_wr_req(dat_wr_req),
        .dat_rd_data(dat_rd_data), .dat_rd_rdy(dat_rd_rdy), .dat_wr_rdy(dat_wr_rdy),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data)
    );

    mem_arbiter16 #(.AW(16), .STARVE_MAX(0)) u_dut0 (
        .clk(clk), .reset(rst),
        .ins_rd_addr(z_ins_addr), .ins_rd_req(z_ins_req),
        .ins_rd_data(z_ins_data), .ins_rd_rdy(z_ins_rdy),
        .dat_rw_addr(z_daddr), .dat_wr_data(z_wdata),
        .dat_rd_req(z_drd), .dat_wr_req(z_dwr),
        .dat_rd_data(z_drd_data), .dat_rd_rdy(z_drd_rdy), .dat_wr_rdy(z_dwr_rdy),
        .mem_addr(z_mem_addr), .mem_wr_data(z_mem_wr_data),
        .mem_wr_en(z_wr_en), .mem_rd_en(z_rd_en), .mem_rd_data(z_mem_rd_data)
    );

    // synchronous single-port RAM model
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic ir, input logic [15:0] ia,
                                input logic dr, input logic dw, input logic [15:0] da,
                                input logic [15:0] wd, input logic [1:0] k,
                                input logic [15:0] rd);
        vec_t v;
        v.rst = r; v.ins_req = ir; v.ins_addr = ia; v.drd = dr; v.dwr = dw;
        v.daddr = da; v.wdata = wd; v.kind = k; v.rdata = rd;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        resp_t e;
        @(posedge clk);
        #1;
        rst = v.rst; ins_rd_req = v.ins_req; ins_rd_addr = v.ins_addr;
        dat_rd_req = v.drd; dat_wr_req = v.dwr; dat_rw_addr = v.daddr; dat_wr_data = v.wdata;
        @(negedge clk);
        e.kind = K_NONE; e.rdata = '0;
        if (sb.size() > 0) e = sb.pop_front();
        if (v.rst) e.kind = K_NONE;
        chk("ins_rd_rdy", 32'(ins_rd_rdy), 32'(e.kind == K_INS));
        chk("dat_rd_rdy", 32'(dat_rd_rdy), 32'(e.kind == K_DRD));
        chk("dat_wr_rdy", 32'(dat_wr_rdy), 32'(e.kind == K_DWR));
        if (e.kind == K_INS) chk("ins_rd_data", 32'(ins_rd_data), 32'(e.rdata));
        if (e.kind == K_DRD) chk("dat_rd_data", 32'(dat_rd_data), 32'(e.rdata));
        chk("mem_rd_en", 32'(mem_rd_en), 32'(v.kind == K_INS || v.kind == K_DRD));
        chk("mem_wr_en", 32'(mem_wr_en), 32'(v.kind == K_DWR));
        if (v.kind == K_INS) chk("mem_addr_ins", 32'(mem_addr), 32'(v.ins_addr));
        if (v.kind == K_DRD || v.kind == K_DWR) chk("mem_addr_dat", 32'(mem_addr), 32'(v.daddr));
        if (v.kind == K_DWR) chk("mem_wr_data", 32'(mem_wr_data), 32'(v.wdata));
        e.kind = v.kind; e.rdata = v.rdata;
        sb.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
        ram[16'h0000] = 16'h1111; ram[16'h0001] = 16'h2222; ram[16'h0002] = 16'h3333;
        ram[16'h0010] = 16'hAAAA; ram[16'h0040] = 16'h4444; ram[16'h0050] = 16'h5555;
        mem_rd_data = '0;
        rst = 1'b1; ins_rd_req = 0; dat_rd_req = 0; dat_wr_req = 0;
        ins_rd_addr = '0; dat_rw_addr = '0; dat_wr_data = '0;
        z_ins_req = 0; z_drd = 0; z_dwr = 0; z_ins_addr = '0; z_daddr = '0;
        z_wdata = '0; z_mem_rd_data = '0;

        // reset
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, K_NONE, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 16'h40, 16'h1, K_NONE, 0));
        // fetch only, addresses 0,1,2
        vecs.push_back(mk(0, 1, 16'h0, 0, 0, 0, 0, K_INS, 16'h1111));
        vecs.push_back(mk(0, 1, 16'h1, 0, 0, 0, 0, K_INS, 16'h2222));
        vecs.push_back(mk(0, 1, 16'h2, 0, 0, 0, 0, K_INS, 16'h3333));
        // store vs fetch collision, then reload the stored word
        vecs.push_back(mk(0, 1, 16'h10, 0, 1, 16'h100, 16'hBEEF, K_DWR, 0));
        vecs.push_back(mk(0, 1, 16'h10, 0, 0, 0, 0, K_INS, 16'hAAAA));
        vecs.push_back(mk(0, 0, 0, 1, 0, 16'h100, 0, K_DRD, 16'hBEEF));
        // starvation: 4 data grants then one forced fetch, twice
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 4; d++)
                vecs.push_back(mk(0, 1, 16'h50, 1, 0, 16'h40, 0, K_DRD, 16'h4444));
            vecs.push_back(mk(0, 1, 16'h50, 1, 0, 16'h40, 0, K_INS, 16'h5555));
        end
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, K_NONE, 0));
        // simultaneous load and store to 0x0020
        vecs.push_back(mk(0, 0, 0, 1, 1, 16'h20, 16'h5A5A, K_DWR, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 16'h20, 0, K_DRD, 16'h5A5A));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, K_NONE, 0));
        // reset in the cycle after a granted load
        vecs.push_back(mk(0, 0, 0, 1, 0, 16'h40, 0, K_DRD, 16'h4444));
        vecs.push_back(mk(1, 0, 0, 1, 0, 16'h40, 0, K_NONE, 0));
        vecs.push_back(mk(0, 1, 16'h1, 0, 0, 0, 0, K_INS, 16'h2222));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, K_NONE, 0));

        foreach (vecs[i]) apply(vecs[i]);

        // STARVE_MAX=0: continuous load starves fetch forever
        @(posedge clk);
        #1;
        z_drd = 1; z_ins_req = 1; z_daddr = 16'h0077; z_ins_addr = 16'h0033;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("z_ins_rd_rdy", 32'(z_ins_rdy), 32'd0);
            chk("z_mem_rd_en", 32'(z_rd_en), 32'd1);
            chk("z_mem_wr_en", 32'(z_wr_en), 32'd0);
            chk("z_mem_addr", 32'(z_mem_addr), 32'h0077);
            chk("z_dat_rd_rdy", 32'(z_drd_rdy), 32'(c > 0));
            @(posedge clk);
            #1;
        end
        z_drd = 0; z_ins_req = 0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter16.md
Name: mem_arbiter16

Overview:
Shares one single-port synchronous 16-bit RAM between the cpu16 instruction-fetch port and data load/store port.
- Issues at most one RAM access per cycle.
- Data accesses have fixed priority; a bounded-starvation counter guarantees forward progress for fetch.
- Returns per-port ready strobes one cycle after each granted access.
- Sits between cpu16 and the on-chip block RAM.

Parameters:
- AW, 16, address width of both ports and the RAM.
- STARVE_MAX, 4, consecutive fetch denials after which fetch is forced to win one cycle; 0 disables forcing (pure data priority).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ins_rd_addr  in  AW  fetch address
- ins_rd_req  in  1  fetch request (level)
- ins_rd_data  out  16  fetch data, valid only while ins_rd_rdy=1
- ins_rd_rdy  out  1  fetch completed (read data valid this cycle)
- dat_rw_addr  in  AW  load/store address
- dat_wr_data  in  16  store data
- dat_rd_req  in  1  load request (level)
- dat_wr_req  in  1  store request (level)
- dat_rd_data  out  16  load data, valid only while dat_rd_rdy=1
- dat_rd_rdy  out  1  load completed
- dat_wr_rdy  out  1  store completed
- mem_addr  out  AW  RAM address
- mem_wr_data  out  16  RAM write data
- mem_wr_en  out  1  RAM write strobe
- mem_rd_en  out  1  RAM read strobe
- mem_rd_data  in  16  RAM read data, valid the cycle after mem_rd_en

Behaviour:
- Reset: ins_rd_rdy, dat_rd_rdy, dat_wr_rdy, mem_wr_en, mem_rd_en all 0; starve_cnt=0; resp register=NONE. mem_addr and mem_wr_data are don't-care while both enables are 0.
- Requests are sampled every cycle; no state is held for ungranted requests. A requester keeps its request and address asserted until it sees its rdy.
- Grant decision (combinational, cycle N), in priority order:
  - reset → none;
  - fetch forced, when STARVE_MAX>0 and starve_cnt==STARVE_MAX and ins_rd_req → INS;
  - dat_wr_req → DWR;
  - dat_rd_req → DRD;
  - ins_rd_req → INS;
  - otherwise none.
- dat_wr_req and dat_rd_req both high: the write is served; the read stays pending and is served in a later cycle.
- Issue in cycle N:
  - INS: mem_addr=ins_rd_addr, mem_rd_en=1.
  - DRD: mem_addr=dat_rw_addr, mem_rd_en=1.
  - DWR: mem_addr=dat_rw_addr, mem_wr_data=dat_wr_data, mem_wr_en=1.
  - mem_rd_en and mem_wr_en are never both 1.
- Response register resp ∈ {NONE, INS, DRD, DWR} is loaded with the grant at posedge.
- Cycle N+1 outputs:
  - ins_rd_rdy=(resp==INS), dat_rd_rdy=(resp==DRD), dat_wr_rdy=(resp==DWR).
  - ins_rd_data and dat_rd_data both pass mem_rd_data directly (combinational).
  - At most one rdy is high per cycle.
- Latency: 1 cycle from grant to rdy. Back-to-back grants are allowed every cycle, so throughput is one access per cycle.
- Starvation counter (saturating, width clog2(STARVE_MAX+1)):
  - increments when ins_rd_req=1 and grant≠INS;
  - clears when grant==INS or ins_rd_req=0;
  - saturates at STARVE_MAX.
- Reset asserted mid-operation: resp is forced to NONE at that edge, so no rdy appears the following cycle. The access issued in the reset cycle is suppressed (enables are 0 during reset).
- Address wrap: mem_addr is passed through unchanged; no arithmetic is performed.

Test Plan:
1. Fetch only: ins_rd_req=1, addresses 0,1,2 on consecutive cycles, RAM preloaded with 0x1111/0x2222/0x3333 → ins_rd_rdy=1 every cycle from cycle 1, ins_rd_data returns 0x1111, 0x2222, 0x3333 in order.
2. Store vs fetch collision: ins_rd_req=1 at 0x0010; dat_wr_req=1, addr 0x0100, data 0xBEEF in the same cycle → mem_wr_en=1 at 0x0100; next cycle dat_wr_rdy=1 and ins_rd_rdy=0; fetch is granted the following cycle; a later load of 0x0100 returns 0xBEEF.
3. Starvation, STARVE_MAX=4: dat_rd_req and ins_rd_req held high continuously → 4 data grants, then 1 forced INS grant, repeating; ins_rd_rdy appears every 5th cycle.
4. Simultaneous load and store to 0x0020 (store data 0x5A5A) → store is granted first, dat_wr_rdy first; load is granted next, dat_rd_rdy with data 0x5A5A.
5. Reset mid-access: load granted in cycle N, reset high in cycle N+1 → dat_rd_rdy=0 and both mem enables=0 during reset. After release, the first fetch returns correct data with 1-cycle latency.
6. STARVE_MAX=0 with continuous dat_rd_req → ins_rd_rdy is never asserted; mem_rd_en=1 every cycle carrying dat_rw_addr.
